// File: rtl/uart_rx_deframer_if.sv
// Byte-wide AXI-stream bundle used on both sides of the UART RX deframer.
// The master drives data, valid and last. The slave returns ready.
interface uart_rx_deframer_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_rx_deframer.sv
// UART RX packet deframer.
// Hunts for SYNC_BYTE in the unframed RX byte stream and validates LEN and
// the checksum, buffering the payload while it does so. Only frames that pass
// every check are replayed downstream as one AXI-stream packet with tlast.
// Frames with a bad length, a bad checksum or an idle timeout are dropped and
// reported on frame_err/err_code.
module uart_rx_deframer #(
    parameter int         MAX_PAYLOAD    = 64,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  resetn,
    uart_rx_deframer_if.slave     s_axis,
    uart_rx_deframer_if.master    m_axis,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic [1:0]            err_code
);
    localparam int IDX_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] ST_HUNT    = 3'd0;
    localparam logic [2:0] ST_LEN     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CHECK   = 3'd3;
    localparam logic [2:0] ST_DRAIN   = 3'd4;

    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CHK     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0]      MAX_LEN = 8'(MAX_PAYLOAD);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state;
    logic [IDX_W-1:0] last_idx;   // LEN-1: index of the final payload byte
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [7:0]       acc;
    logic [TO_W-1:0]  idle_cnt;
    logic [7:0]       buf_mem [MAX_PAYLOAD];

    logic             s_hs;
    logic             m_hs;
    logic             in_frame;
    logic [7:0]       chk_sum;
    logic [IDX_W-1:0] rd_next;

    assign s_axis.tready = (state != ST_DRAIN);
    assign s_hs          = s_axis.tvalid && s_axis.tready;
    assign m_hs          = m_axis.tvalid && m_axis.tready;
    assign in_frame      = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHECK);
    assign chk_sum       = acc + s_axis.tdata;
    assign rd_next       = rd_idx + IDX_W'(1);

    // Payload store; contents only matter between CHECK and the end of DRAIN.
    always_ff @(posedge clk) begin
        if (state == ST_PAYLOAD && s_hs) begin
            buf_mem[wr_idx] <= s_axis.tdata;
        end
    end

    // Frame parser, idle timeout and registered downstream/status outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= ST_HUNT;
            last_idx      <= '0;
            wr_idx        <= '0;
            rd_idx        <= '0;
            acc           <= '0;
            idle_cnt      <= '0;
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
            m_axis.tdata  <= '0;
            frame_ok      <= 1'b0;
            frame_err     <= 1'b0;
            err_code      <= '0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            // The counter stays at zero outside the frame, so entering LEN starts it clean.
            if (in_frame && !s_hs) begin
                idle_cnt <= idle_cnt + TO_W'(1);
            end else begin
                idle_cnt <= '0;
            end

            case (state)
                ST_HUNT: begin
                    if (s_hs && s_axis.tdata == SYNC_BYTE) begin
                        state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (s_hs) begin
                        if (s_axis.tdata == 8'd0 || s_axis.tdata > MAX_LEN) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_LEN;
                            state     <= ST_HUNT;
                        end else begin
                            last_idx <= IDX_W'(s_axis.tdata - 8'd1);
                            acc      <= s_axis.tdata;
                            wr_idx   <= '0;
                            state    <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (s_hs) begin
                        acc    <= chk_sum;
                        wr_idx <= wr_idx + IDX_W'(1);
                        if (wr_idx == last_idx) begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (s_hs) begin
                        if (chk_sum == 8'd0) begin
                            // Present the first byte right away so release costs one cycle.
                            frame_ok      <= 1'b1;
                            m_axis.tvalid <= 1'b1;
                            m_axis.tdata  <= buf_mem[0];
                            m_axis.tlast  <= (last_idx == '0);
                            rd_idx        <= '0;
                            state         <= ST_DRAIN;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_CHK;
                            state     <= ST_HUNT;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (m_hs) begin
                        if (m_axis.tlast) begin
                            m_axis.tvalid <= 1'b0;
                            m_axis.tlast  <= 1'b0;
                            state         <= ST_HUNT;
                        end else begin
                            rd_idx       <= rd_next;
                            m_axis.tdata <= buf_mem[rd_next];
                            m_axis.tlast <= (rd_next == last_idx);
                        end
                    end
                end
                default: state <= ST_HUNT;
            endcase

            // The last permitted idle cycle ends the frame. No byte arrives in that cycle.
            if (in_frame && !s_hs && idle_cnt == TO_LAST) begin
                frame_err <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                state     <= ST_HUNT;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed testbench for uart_rx_deframer with a frame-level reference model.
module tb_uart_rx_deframer;
    localparam int MAXP = 64;
    localparam int TO   = 16;

    logic       clk = 1'b0;
    logic       resetn;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    uart_rx_deframer_if s_axis ();
    uart_rx_deframer_if m_axis ();

    uart_rx_deframer #(
        .MAX_PAYLOAD(MAXP),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .s_axis(s_axis),
        .m_axis(m_axis),
        .frame_ok(frame_ok),
        .frame_err(frame_err),
        .err_code(err_code)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [8:0] exp_q[$];       // {tlast, tdata} still owed downstream
    int         ev_q[$];        // 0 = frame_ok, otherwise the expected err_code
    int         popped   = 0;
    bit         rand_ready = 1'b0;
    logic [7:0] pl [MAXP];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Model checksum: the value that makes LEN + payload + CHK wrap to zero.
    function automatic logic [7:0] chk_of(input int n);
        int sum;
        sum = n;
        for (int i = 0; i < n; i++) sum += pl[i];
        return 8'((256 - (sum % 256)) % 256);
    endfunction

    // Downstream ready: always 1, or a random pattern when rand_ready is set.
    initial begin
        m_axis.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Per-cycle compare of the DUT outputs against the expected streams.
    bit         prev_stall = 1'b0;
    logic [7:0] prev_d;
    logic       prev_l;
    always @(negedge clk) begin
        if (!resetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", m_axis.tvalid, 1);
                check("stall_data", m_axis.tdata, prev_d);
                check("stall_last", m_axis.tlast, prev_l);
            end
            if (m_axis.tvalid) check("drain_sready", s_axis.tready, 0);
            if (m_axis.tvalid && m_axis.tready) begin
                check("out_pending", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    popped++;
                    check("out_data", m_axis.tdata, e[7:0]);
                    check("out_last", m_axis.tlast, e[8]);
                end
            end
            if (frame_ok || frame_err) begin
                check("ok_err_excl", int'(frame_ok && frame_err), 0);
                check("event_pending", int'(ev_q.size() > 0), 1);
                if (ev_q.size() > 0) begin
                    int e;
                    e = ev_q.pop_front();
                    check("event_kind", frame_err ? int'(err_code) : 0, e);
                end
            end
            prev_stall = m_axis.tvalid && !m_axis.tready;
            prev_d     = m_axis.tdata;
            prev_l     = m_axis.tlast;
        end
    end

    // Offer one byte and return after its handshake edge (+1).
    task automatic send_byte(input logic [7:0] b, output int waited);
        bit hs;
        waited        = 0;
        hs            = 1'b0;
        s_axis.tdata  = b;
        s_axis.tvalid = 1'b1;
        while (!hs) begin
            hs = s_axis.tready;
            @(posedge clk);
            #1;
            if (!hs) begin
                waited++;
                if (waited > 3000) begin
                    check("send_hs", int'(hs), 1);
                    break;
                end
            end
        end
    endtask

    // Send SYNC, LEN, pl[0..LEN-1], CHK. The model decides the outcome from the frame rules.
    task automatic send_frame(input logic [7:0] lenb, input logic [7:0] chk);
        int w;
        int sum;
        send_byte(8'hA5, w);
        if (lenb == 8'd0 || lenb > MAXP) begin
            ev_q.push_back(1);
            send_byte(lenb, w);
            @(negedge clk);
            check("len_err_pulse", frame_err, 1);
            check("len_err_code", err_code, 1);
            check("len_err_novalid", m_axis.tvalid, 0);
        end else begin
            send_byte(lenb, w);
            sum = lenb;
            for (int i = 0; i < lenb; i++) begin
                send_byte(pl[i], w);
                sum += pl[i];
            end
            sum += chk;
            if (sum % 256 == 0) begin
                for (int i = 0; i < lenb; i++) exp_q.push_back({(i == lenb - 1), pl[i]});
                ev_q.push_back(0);
            end else begin
                ev_q.push_back(2);
            end
            send_byte(chk, w);
            @(negedge clk);
            if (sum % 256 == 0) begin
                check("release_ok", frame_ok, 1);
                check("release_valid", m_axis.tvalid, 1);
                check("release_data", m_axis.tdata, pl[0]);
                check("release_last", m_axis.tlast, int'(lenb == 8'd1));
            end else begin
                check("chk_err_pulse", frame_err, 1);
                check("chk_err_code", err_code, 2);
                check("chk_err_novalid", m_axis.tvalid, 0);
            end
        end
        s_axis.tvalid = 1'b0;
    endtask

    task automatic wait_drain(output int cyc);
        cyc = 0;
        #1;
        while (exp_q.size() > 0 && cyc < 3000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("drain_done", exp_q.size(), 0);
        @(negedge clk);
        check("sready_after_drain", s_axis.tready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "testbench time limit");
    end

    initial begin
        int w;
        int cyc;
        resetn        = 1'b0;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = 8'h00;
        s_axis.tlast  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sready", s_axis.tready, 1);
        check("rst_mvalid", m_axis.tvalid, 0);
        check("rst_mlast", m_axis.tlast, 0);
        check("rst_mdata", m_axis.tdata, 0);
        check("rst_ok", frame_ok, 0);
        check("rst_err", frame_err, 0);
        check("rst_code", err_code, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Scenario 1: good frame A5 03 11 22 33 97
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        check("pin_chk3", chk_of(3), 8'h97);
        send_frame(8'h03, 8'h97);
        wait_drain(cyc);
        check("drain_cycles", cyc, 2);

        // Scenario 2: leading garbage
        send_byte(8'h00, w);
        check("garbage0_ready", w, 0);
        send_byte(8'hFF, w);
        check("garbage1_ready", w, 0);
        s_axis.tvalid = 1'b0;
        send_frame(8'h03, 8'h97);
        wait_drain(cyc);
        check("drain_cycles2", cyc, 2);

        // Scenario 3: bad checksum, then a good frame immediately after
        send_frame(8'h03, 8'h98);
        send_frame(8'h03, 8'h97);
        wait_drain(cyc);

        // Scenario 4: length errors, each followed directly by a new frame
        send_frame(8'h00, 8'h00);
        send_frame(8'h41, 8'h00);
        send_frame(8'h03, 8'h97);
        wait_drain(cyc);

        // Scenario 5a: timeout after A5 03 11 22
        send_byte(8'hA5, w); send_byte(8'h03, w); send_byte(8'h11, w); send_byte(8'h22, w);
        s_axis.tvalid = 1'b0;
        ev_q.push_back(3);
        for (int k = 1; k <= TO + 1; k++) begin
            @(negedge clk);
            check("timeout_err_timing", frame_err, int'(k == TO + 1));
        end
        check("timeout_code", err_code, 3);
        check("timeout_novalid", m_axis.tvalid, 0);
        @(posedge clk);
        #1;

        // Scenario 5b: a stall one cycle short of the timeout completes normally
        send_byte(8'hA5, w); send_byte(8'h03, w); send_byte(8'h11, w); send_byte(8'h22, w);
        s_axis.tvalid = 1'b0;
        repeat (TO - 1) @(posedge clk);
        #1;
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b1, 8'h33});
        ev_q.push_back(0);
        send_byte(8'h33, w);
        send_byte(8'h97, w);
        s_axis.tvalid = 1'b0;
        @(negedge clk);
        check("stall_short_ok", frame_ok, 1);
        check("stall_short_valid", m_axis.tvalid, 1);
        wait_drain(cyc);

        // Scenario 6: full-length frame with random downstream backpressure
        for (int i = 0; i < MAXP; i++) pl[i] = 8'(i);
        check("pin_chk64", chk_of(64), 8'hE0);
        rand_ready = 1'b1;
        send_frame(8'h40, 8'hE0);
        wait_drain(cyc);

        // Scenario 6 repeat: reset pulsed mid-drain discards the frame
        popped = 0;
        send_frame(8'h40, 8'hE0);
        cyc = 0;
        while (popped < 10 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_drain_reached", int'(popped >= 10), 1);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        exp_q.delete();
        ev_q.delete();
        @(negedge clk);
        check("rst_drain_novalid", m_axis.tvalid, 0);
        check("rst_drain_sready", s_axis.tready, 1);
        check("rst_drain_noerr", frame_err, 0);
        rand_ready = 1'b0;

        // Back in HUNT: a short frame goes through cleanly
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_frame(8'h03, 8'h97);
        wait_drain(cyc);

        repeat (3) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        check("ev_q_empty", ev_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Packet deframer on the UART receive path. It reads the byte stream from the RX FIFO, which carries no packet boundaries. It hunts for a sync byte, checks length and checksum, and buffers the whole payload. Only frames that pass every check are released downstream as an AXI-stream packet with `tlast`, which restores the framing the transmit side accepts through its `last` input. Bad, oversized or stalled frames are dropped whole and reported on error pulses.

## Interface
- `MAX_PAYLOAD`, 64: maximum payload bytes per frame; also the depth of the internal buffer.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, 100000: consecutive idle clock cycles inside a frame before the frame is abandoned.
- `clk`  in  1  single clock domain.
- `resetn`  in  1  reset; synchronous, active-low.
- `s_axis_tdata`  in  8  received byte from the RX FIFO.
- `s_axis_tvalid`  in  1  byte available.
- `s_axis_tready`  out  1  deframer accepts the byte.
- `m_axis_tdata`  out  8  payload byte.
- `m_axis_tvalid`  out  1  payload byte valid.
- `m_axis_tready`  in  1  downstream accepts the byte.
- `m_axis_tlast`  out  1  last payload byte of the frame.
- `frame_ok`  out  1  one-cycle pulse when a frame passes its checks.
- `frame_err`  out  1  one-cycle pulse when a frame is dropped.
- `err_code`  out  2  cause of the drop: 01 length, 10 checksum, 11 timeout; valid while `frame_err`=1, holds its last value otherwise.

## Operation
- Frame format: `SYNC_BYTE`, then `LEN` (1..`MAX_PAYLOAD`), then `LEN` payload bytes, then `CHK`.
- Checksum rule: (`LEN` + sum of payload + `CHK`) mod 256 == 0. Use an 8-bit wrapping accumulator.
- No byte escaping: a payload byte equal to `SYNC_BYTE` is treated as data.
- A byte is accepted when `s_axis_tvalid` & `s_axis_tready`.
- States and transitions:
  - HUNT: discard accepted bytes silently. An accepted `SYNC_BYTE` moves to LEN.
  - LEN: accepted byte 0 or >`MAX_PAYLOAD` raises a length error and returns to HUNT. Otherwise store the length, load the accumulator with `LEN`, clear the write index, and move to PAYLOAD.
  - PAYLOAD: write each accepted byte to `buf[wr_idx]` and add it to the accumulator. The byte with `wr_idx`==`LEN`-1 moves to CHECK.
  - CHECK: the accepted byte is `CHK`. If the sum is zero, move to DRAIN; otherwise raise a checksum error and return to HUNT.
  - DRAIN: present `buf[rd_idx]`. Each downstream handshake increments `rd_idx`. The handshake with `tlast` returns to HUNT.
- `s_axis_tready`=1 in HUNT, LEN, PAYLOAD and CHECK; 0 in DRAIN. Backpressure holds in the RX FIFO.
- Timeout counter:
  - Cleared on entry to LEN and on every accepted byte.
  - Increments every cycle in LEN, PAYLOAD or CHECK when no byte is accepted.
  - On reaching `TIMEOUT_CYCLES` it raises a timeout error and returns to HUNT.
  - Inactive in HUNT and DRAIN.
  - Width is $clog2(`TIMEOUT_CYCLES`+1).
- Dropped frames produce no `m_axis_tvalid`. Buffer contents are don't-care outside DRAIN.

## Timing
- Reset state: HUNT; `s_axis_tready`=1 (the only output reset to 1); `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `frame_ok`=0, `frame_err`=0, `err_code`=00.
- `resetn` low mid-frame or mid-drain discards the frame. `m_axis_tvalid`=0 from the cycle after the reset edge, with no error pulse.
- Acceptance rate: one byte per cycle in every accepting state.
- Release latency: `frame_ok` and the first `m_axis_tvalid` are both asserted in the cycle after the `CHK` handshake.
- Drain throughput: one byte per cycle while `m_axis_tready`=1.
- Stall rule: while `m_axis_tvalid`=1 and `m_axis_tready`=0, `m_axis_tdata` and `m_axis_tlast` hold stable. `tvalid` never drops before its handshake.
- `m_axis_tlast` is 1 only when `rd_idx`==`LEN`-1.
- End of drain: `s_axis_tready` returns to 1 in the cycle after the last handshake.
- `frame_err` is registered: it pulses in the cycle after the offending `LEN`/`CHK` handshake, or after the `TIMEOUT_CYCLES`-th consecutive idle cycle. The state is already HUNT in that cycle, so a `SYNC_BYTE` offered then is accepted.

## Test plan
1. Good frame: A5 03 11 22 33 97 back-to-back -> `m_axis` outputs 11, 22, 33 on consecutive cycles, `tlast` only on 33; one `frame_ok` pulse; `frame_err` stays 0.
2. Leading garbage: 00 FF A5 then frame 1 -> garbage consumed with `s_axis_tready`=1 and no error; output identical to scenario 1.
3. Bad checksum: A5 03 11 22 33 98 -> no `m_axis_tvalid`; `frame_err` with `err_code`=10. An immediately following good frame is output intact.
4. Length errors: A5 00, then A5 41 (`MAX_PAYLOAD`=64) -> two `frame_err` pulses with `err_code`=01. The byte after each is hunted (A5 starts a new frame).
5. Timeout: A5 03 11 22, then `s_axis_tvalid`=0 -> `frame_err` with `err_code`=11 exactly `TIMEOUT_CYCLES`+1 cycles after the 22 handshake (run with `TIMEOUT_CYCLES`=16); nothing output. A stall of `TIMEOUT_CYCLES`-1 cycles completes normally.
6. Full-length frame under backpressure: 64-byte payload 00..3F with random `m_axis_tready` -> all 64 bytes in order, data stable while stalled, `tlast` only on 3F, `s_axis_tready`=0 throughout DRAIN. A repeat run with `resetn` pulsed mid-drain -> `tvalid`=0 next cycle, state HUNT.
